// File: rtl/timer_pkg.sv
// Shared timer definitions: state encodings and a prescaler width helper.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;

    // Prescaler register width; never below 1 bit so DIV=1 still has a register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Control and status bundle of the phase timer.
interface phase_timer_if #(
    parameter int WIDTH = 13
);
    logic [WIDTH-1:0] load_value;
    logic             load;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             expire;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output load_value, load, enable, auto_reload,
        input  count, zero, expire, busy, state
    );

    modport slave (
        input  load_value, load, enable, auto_reload,
        output count, zero, expire, busy, state
    );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every DIV enabled cycles, holds while idle.
module tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int unsigned   PW   = presc_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_presc;

    // Prescaler count: clear wins, advance only while running, wrap at DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= (r_presc == LAST) ? '0 : r_presc + ONE;
        end
    end

    assign tick = run && (r_presc == LAST);

endmodule

// File: rtl/phase_timer.sv
// Down-counting phase timer with prescaler, pause and optional auto-reload.
//
// state | meaning
// IDLE  | after reset, count 0, waits for load
// RUN   | counting down on prescaler ticks
// PAUSE | enable low, count and prescaler frozen
// DONE  | expired (or loaded with 0), count 0 until next load
module phase_timer
    import timer_pkg::*;
#(
    parameter int          WIDTH = 13,
    parameter int unsigned DIV   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    phase_timer_if.slave   bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_expire;
    logic             w_expire_nxt;
    logic             w_run;
    logic             w_tick;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    assign w_run = (r_state == RUN) && bus.enable;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (bus.load),
        .tick  (w_tick)
    );

    // State, count and expire registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    // Next-state, next-count and expire decode; load overrides every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_expire_nxt = 1'b0;
        if (bus.load) begin
            w_count_nxt = bus.load_value;
            w_state_nxt = (bus.load_value != '0) ? RUN : DONE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_count_nxt = '0;
                end
                RUN: begin
                    if (!bus.enable) begin
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        if (r_count > CNT_ONE) begin
                            w_count_nxt = r_count - CNT_ONE;
                        end else if (r_count == CNT_ONE) begin
                            w_expire_nxt = 1'b1;
                            if (bus.auto_reload && (bus.load_value != '0)) begin
                                w_count_nxt = bus.load_value;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = DONE;
                            end
                        end else begin
                            // Count already 0 in RUN is unreachable; park safely without a pulse.
                            w_count_nxt = '0;
                            w_state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.enable) begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_count_nxt = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign bus.count  = r_count;
    assign bus.expire = r_expire;
    assign bus.state  = r_state;
    assign bus.zero   = (r_count == '0);
    assign bus.busy   = (r_state == RUN) || (r_state == PAUSE);

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter WIDTH, 13, bit width of load_value and count.
REQ-002 Parameter DIV, 1, clock cycles per count step; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_value  input  WIDTH  unsigned preset value, sampled only when load=1.
REQ-006 load  input  1  synchronous load/start strobe; highest priority after reset.
REQ-007 enable  input  1  count enable; 0 pauses counting.
REQ-008 auto_reload  input  1  1 = reload load_value on expiry instead of stopping.
REQ-009 count  output  WIDTH  current remaining count, registered.
REQ-010 zero  output  1  level, high when count==0.
REQ-011 expire  output  1  registered one-cycle pulse on each expiry.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-014 Tick: high for one cycle when state==RUN, enable==1 and prescaler==DIV-1; the prescaler then wraps to 0.
REQ-015 Prescaler advances only when state==RUN and enable==1; it holds otherwise and clears on load.
REQ-016 DIV=1: every enabled RUN cycle is a tick; prescaler register is at least 1 bit wide.
REQ-017 load=1 in any state: count<=load_value, prescaler<=0, expire<=0; next state RUN if load_value!=0, else DONE.
REQ-018 Loading load_value==0 never raises expire.
REQ-019 IDLE: count holds 0; leaves only on load.
REQ-020 RUN, enable==0, no load: next state PAUSE; count and prescaler hold; no tick that cycle.
REQ-021 PAUSE: count and prescaler hold; enable==1 returns to RUN the next cycle; counting resumes from the held prescaler value.
REQ-022 RUN, tick, count>1: count<=count-1.
REQ-023 RUN, tick, count==1, auto_reload==0: count<=0, expire<=1, next state DONE.
REQ-024 RUN, tick, count==1, auto_reload==1, load_value!=0: count<=load_value, expire<=1, state stays RUN.
REQ-025 RUN, tick, count==1, auto_reload==1, load_value==0: behave as REQ-023.
REQ-026 Count never wraps below 0; all arithmetic is WIDTH-bit unsigned; load_value=2^WIDTH-1 is legal.
REQ-027 DONE: count holds 0 and zero=1 until load.
REQ-028 expire is high exactly in the cycle in which count first shows the post-expiry value; it is low in every other cycle.
REQ-029 Latency: count reflects load_value one cycle after load; each tick updates count at the same edge.

Reset
REQ-030 rst_n low: count=0, prescaler=0, state=IDLE, expire=0 immediately, regardless of clk.
REQ-031 Reset outputs: zero=1, busy=0, state=00.
REQ-032 Reset mid-count discards all progress; the first edge after release with load=0 stays IDLE.

Structure
REQ-033 State encodings (IDLE, RUN, PAUSE, DONE) are localparams in shared package timer_pkg, reused by all traffic-light controllers.
REQ-034 The prescaler is a sub-module tick_gen (parameter DIV; ports clk, rst_n, run, clear, tick).
REQ-035 All outputs come directly from registers or from single comparisons on registers (zero, busy).

Verification
REQ-036 WIDTH=13, DIV=1: load 3, enable=1, auto_reload=0 -> count 3,2,1,0 on successive cycles; expire high only with count=0; state DONE; count holds 0.
REQ-037 Load 10, enable=1 for 3 ticks -> 7; enable=0 for 5 cycles -> count 7, state PAUSE; enable=1 -> 6 two cycles later, then continues to 0.
REQ-038 Load 2, auto_reload=1 -> 2,1,2,1,...; expire every 2nd cycle; zero never high; busy stays 1.
REQ-039 Count at 4 in RUN, load 100 -> next count 100, prescaler 0; load 0 -> state DONE, zero=1, no expire.
REQ-040 DIV=4: load 2, enable=1 -> count steps every 4 cycles; expire 8 cycles after the load edge; count reaches 0 without wrap.
REQ-041 Load 5, run 2 ticks, assert rst_n asynchronously between edges -> count 0, state IDLE, zero=1, expire 0 before next edge.
